// File: rtl/lab_readout_engine.sv
// LAB readout engine: strobes digitize on the masked LABs, then streams each LAB's
// RAM words, in LAB order, through a small output FIFO that cannot overflow.
module lab_readout_engine #(
    parameter int NWORDS     = 1536,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [3:0]  lab_mask_i,
    output logic [3:0]  digitize_o,
    output logic [12:0] addr_o,
    input  logic [31:0] dat_i,
    input  logic        done_i,
    output logic [31:0] dat_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic [1:0]  lab_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  timeout_o
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 21) ? $clog2(TIMEOUT + 1) : 21;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIGITIZE, S_SELECT, S_WAIT_DONE, S_READ, S_DRAIN, S_FINISH
    } state_t;

    typedef struct packed {
        logic [1:0]  lab;
        logic        last;
        logic [31:0] dat;
    } entry_t;

    state_t        r_state;
    logic [3:0]    r_pending;
    logic [TW-1:0] r_wait_cnt;
    logic [10:0]   r_word;
    logic [1:0]    r_lab;
    logic [3:0]    r_digitize;
    logic [3:0]    r_timeout;
    logic          r_busy;
    logic          r_done;

    logic          r_pipe_vld  [RD_LATENCY];
    logic [1:0]    r_pipe_lab  [RD_LATENCY];
    logic          r_pipe_last [RD_LATENCY];
    logic [CW-1:0] r_inflight;

    entry_t        r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_valid;
    logic          w_pop;
    logic          w_retire;
    logic          w_issue;
    logic          w_last_word;
    logic          w_any;
    logic [1:0]    w_sel_lab;
    logic [CW:0]   w_occ;
    entry_t        w_head;

    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & ready_i;
    assign w_retire    = r_pipe_vld[RD_LATENCY-1];
    // A read is only issued when its FIFO slot is already guaranteed.
    assign w_occ       = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue     = (r_state == S_READ) && (w_occ < (CW + 1)'(FIFO_DEPTH));
    assign w_last_word = (r_word == 11'(NWORDS - 1));
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        w_any     = |r_pending;
        w_sel_lab = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) w_sel_lab = 2'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_lab[i]  <= 2'd0;
                r_pipe_last[i] <= 1'b0;
            end
            r_inflight <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            r_pipe_vld[0]  <= w_issue;
            r_pipe_lab[0]  <= r_lab;
            r_pipe_last[0] <= w_last_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_lab[i]  <= r_pipe_lab[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_retire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_retire) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_retire) - CW'(w_pop);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the reset count and output gating hide stale entries.
    always_ff @(posedge clk_i) begin
        if (w_retire) r_mem[r_wr_ptr] <= {r_pipe_lab[RD_LATENCY-1], r_pipe_last[RD_LATENCY-1], dat_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_pending  <= 4'd0;
            r_wait_cnt <= '0;
            r_word     <= 11'd0;
            r_lab      <= 2'd0;
            r_digitize <= 4'd0;
            r_timeout  <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_digitize <= 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_pending <= lab_mask_i;
                        r_timeout <= 4'd0;
                        r_busy    <= 1'b1;
                        if (lab_mask_i == 4'd0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_digitize <= lab_mask_i;
                            r_state    <= S_DIGITIZE;
                        end
                    end
                end
                S_DIGITIZE: r_state <= S_SELECT;
                S_SELECT: begin
                    if (w_any) begin
                        r_lab                <= w_sel_lab;
                        r_word               <= 11'd0;
                        r_pending[w_sel_lab] <= 1'b0;
                        r_wait_cnt           <= '0;
                        r_state              <= S_WAIT_DONE;
                    end else begin
                        r_state <= S_FINISH;
                    end
                end
                S_WAIT_DONE: begin
                    if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + TW'(1);
                    // done_i from the previously selected LAB may still be settling for two cycles.
                    if (r_wait_cnt >= TW'(2) && done_i) begin
                        r_state <= S_READ;
                    end else if (r_wait_cnt >= TW'(TIMEOUT - 1)) begin
                        r_timeout[r_lab] <= 1'b1;
                        r_state          <= S_SELECT;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        if (w_last_word) begin
                            r_word  <= 11'd0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_word <= r_word + 11'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0) r_state <= S_SELECT;
                end
                S_FINISH: begin
                    if (r_count == '0 && r_inflight == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign digitize_o = r_digitize;
    assign addr_o     = {r_lab, r_word};
    assign valid_o    = w_valid;
    assign dat_o      = w_valid ? w_head.dat  : 32'd0;
    assign lab_o      = w_valid ? w_head.lab  : 2'd0;
    assign last_o     = w_valid ? w_head.last : 1'b0;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign timeout_o  = r_timeout;

endmodule

// File: doc/lab_readout_engine.md
LAB_READOUT_ENGINE -- requirements
Module: lab_readout_engine

Interface
REQ-001 SHALL have parameter NWORDS, default 1536, giving 32-bit words read per LAB.
REQ-002 SHALL have parameter RD_LATENCY, default 1, giving clocks from addr_o change to valid dat_i.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving output buffer entries (power of 2, at least RD_LATENCY+1).
REQ-004 SHALL have parameter TIMEOUT, default 1000000, giving the clock limit for done_i wait per LAB.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk_i in 1 is the system clock; rst_n_i in 1 is the async active-low reset.
REQ-006 start_i in 1: one-cycle request to begin an event.
REQ-007 lab_mask_i in 4: LABs to digitize/read, sampled with start_i.
REQ-008 digitize_o out 4: per-LAB digitize strobe.
REQ-009 addr_o out 13: [12:11] LAB select, [10:0] word address.
REQ-010 dat_i in 32: RAM data for addr_o.
REQ-011 done_i in 1: readout-complete flag of the LAB selected by addr_o[12:11].
REQ-012 dat_o out 32: stream data.
REQ-013 valid_o out 1: dat_o valid.
REQ-014 ready_i in 1: consumer accepts.
REQ-015 last_o out 1: final word of current LAB.
REQ-016 lab_o out 2: LAB index of dat_o.
REQ-017 busy_o out 1: event in progress.
REQ-018 done_o out 1: one-cycle event-complete pulse.
REQ-019 timeout_o out 4: per-LAB sticky timeout flags.

Function
REQ-020 States SHALL be IDLE, DIGITIZE, SELECT, WAIT_DONE, READ, DRAIN, FINISH.
REQ-021 IDLE + start_i: latch mask, clear timeout_o, assert busy_o, go DIGITIZE; start_i outside IDLE SHALL be ignored.
REQ-022 A zero mask SHALL go straight to FINISH: no digitize, done_o one cycle later.
REQ-023 DIGITIZE SHALL assert digitize_o = latched mask for exactly one cycle, then go to SELECT.
REQ-024 SELECT SHALL pick the lowest-index unserviced masked LAB, drive addr_o[12:11] = index and addr_o[10:0] = 0, then go WAIT_DONE; with none left it SHALL go FINISH.
REQ-025 WAIT_DONE SHALL ignore done_i for its first 2 cycles, then go READ on done_i = 1.
REQ-026 If done_i stays low for TIMEOUT cycles in WAIT_DONE, the block SHALL set timeout_o[lab], read no words for that LAB, and return to SELECT.
REQ-027 READ SHALL issue word addresses 0..NWORDS-1 in order, at most one per cycle, and only when FIFO occupancy plus in-flight reads is below FIFO_DEPTH.
REQ-028 Each issued read SHALL write dat_i into the FIFO exactly RD_LATENCY cycles after issue, tagged with LAB index and a last flag (address NWORDS-1).
REQ-029 After the final issue the block SHALL go to DRAIN and wait until in-flight reads reach 0, then return to SELECT; the FIFO need not be empty.
REQ-030 valid_o SHALL equal FIFO non-empty; a word pops on valid_o & ready_i; dat_o/lab_o/last_o SHALL stay stable while valid_o & !ready_i.
REQ-031 FIFO SHALL never overflow; simultaneous push and pop at full or empty SHALL be handled with no loss or duplication.
REQ-032 FINISH SHALL wait for FIFO empty, then pulse done_o for one cycle, deassert busy_o, and go IDLE.
REQ-033 Word and address counters SHALL wrap per LAB; addr_o[10:0] SHALL never exceed NWORDS-1.
REQ-034 The timeout counter SHALL be at least 21 bits wide, reset on each WAIT_DONE entry, and saturate.

Reset
REQ-035 rst_n_i low SHALL immediately force IDLE and drive digitize_o=0, addr_o=0, valid_o=0, last_o=0, lab_o=0, dat_o=0, busy_o=0, done_o=0, timeout_o=0, and flush the FIFO and in-flight reads.
REQ-036 Reset mid-event SHALL discard all pending data; no done_o SHALL follow the release.

Verification
REQ-037 Mask 4'b0101, done_i after 50 cycles, ready_i=1: digitize_o=0101 for 1 cycle; 1536 words of LAB0 then 1536 of LAB2; last_o on each 1536th; one done_o.
REQ-038 Mask 4'b0010, done_i never high, TIMEOUT=100: timeout_o=0010 after about 100 cycles in WAIT_DONE; no valid_o; done_o pulses.
REQ-039 ready_i toggled randomly 50%, RD_LATENCY=2: output matches RAM model words 0..1535 in order with none dropped or duplicated.
REQ-040 ready_i=0 for 100 cycles during READ: at most 4 words buffered, addr_o stalls, dat_o is held stable.
REQ-041 rst_n_i pulsed low at word 700: all outputs are 0 at once; after release busy_o=0 and no done_o appears.
REQ-042 Mask 0: done_o pulses on the cycle after start_i, and digitize_o stays 0.
